// File: rtl/uart_send_fifo.sv
// uart_send_fifo: byte FIFO feeding an 8N1 UART transmitter (LSB first).
// Bytes enter over a valid/ready handshake. Whenever the FIFO is non-empty,
// the transmitter pulls the head byte and sends it. When the FIFO still holds
// a byte at the end of a stop bit, the next start bit follows on the next
// cycle with no idle gap. The serial line and the busy flag come from
// registers, so neither output can glitch.
module uart_send_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int UART_BPS   = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,   // active-high synchronous reset
   input  logic                          tx_valid,
   input  logic [7:0]                    tx_data,
   output logic                          tx_ready,
   output logic                          uart_txd,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int BPS_CNT = CLK_FREQ / UART_BPS;

   localparam logic [15:0]      BPS_LAST = 16'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // FIFO storage and bookkeeping
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   // Transmitter state
   logic [1:0]  state_q,   state_d;
   logic [15:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q,   shift_d;
   logic        txd_q,     txd_d;
   logic        busy_q,    busy_d;

   logic push_s;
   logic pop_s;
   logic bit_end_s;
   logic not_empty_s;

   assign tx_ready    = (count_q != FULL_CNT) && !sys_rst_n;
   assign push_s      = tx_valid && tx_ready;
   assign not_empty_s = (count_q != CNT_ZERO);
   assign bit_end_s   = (clk_cnt_q == BPS_LAST);

   assign uart_txd    = txd_q;
   assign tx_busy     = busy_q;
   assign fifo_count  = count_q;

   // Transmitter next state: bit timing, bit index, and popping the FIFO head into the shifter
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            clk_cnt_d = 16'd0;
            if (not_empty_s) begin
               pop_s   = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               clk_cnt_d = 16'd0;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               clk_cnt_d = 16'd0;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               clk_cnt_d = 16'd0;
               if (not_empty_s) begin
                  // Chain straight into the next frame without an idle gap.
                  pop_s   = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         default: begin
            clk_cnt_d = 16'd0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // Line level and busy flag for the state being entered, so that both outputs can be registered
   always_comb begin
      txd_d  = 1'b1;
      busy_d = (state_d != ST_IDLE);
      case (state_d)
         ST_IDLE:  txd_d = 1'b1;
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_d[bit_idx_d];
         ST_STOP:  txd_d = 1'b1;
         default:  txd_d = 1'b1;
      endcase
   end

   // FIFO pointer and occupancy update; simultaneous push and pop keep the count
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset; reset also discards any queued bytes
   always_ff @(posedge sys_clk) begin
      if (sys_rst_n) begin
         state_q   <= ST_IDLE;
         clk_cnt_q <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         wr_ptr_q  <= {PTR_W{1'b0}};
         rd_ptr_q  <= {PTR_W{1'b0}};
         count_q   <= CNT_ZERO;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // FIFO data array write; contents need no reset because the count gates every read
   always_ff @(posedge sys_clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= tx_data;
      end
   end

endmodule

// File: tb/tb_uart_send_fifo.sv
// Directed bench for uart_send_fifo with BPS_CNT = 10 and a 4-entry FIFO.
// An independent serial receiver model decodes uart_txd into rx_q.
module tb_uart_send_fifo;

   localparam int BPS = 10;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       uart_txd;
   logic       tx_busy;
   logic [2:0] fifo_count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] rx_q [$];
   int         rx_ferr = 0;

   uart_send_fifo #(
      .CLK_FREQ   (1000),
      .UART_BPS   (100),
      .FIFO_DEPTH (4)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .uart_txd   (uart_txd),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Receiver model: finds the start bit, samples each bit mid-way, and needs a high stop bit
   initial begin : rx_model
      bit         active;
      int         cnt;
      logic [7:0] sh;
      active = 1'b0;
      cnt    = 0;
      sh     = 8'h00;
      forever begin
         @(negedge sys_clk);
         if (sys_rst_n === 1'b1) begin
            active = 1'b0;
         end else if (!active) begin
            if (uart_txd === 1'b0) begin
               active = 1'b1;
               cnt    = 0;
            end
         end else begin
            cnt++;
            if (cnt < 9 * BPS && (cnt % BPS) == BPS / 2 - 1 && cnt > BPS) begin
               sh[3'(cnt / BPS - 1)] = uart_txd;
            end
            if (cnt == 9 * BPS + BPS / 2 - 1) begin
               if (uart_txd === 1'b1) rx_q.push_back(sh);
               else rx_ferr++;
               active = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Walks one 10-bit frame from its first start-bit cycle, counting line and busy deviations
   task automatic observe_frame(input logic [7:0] b, output int errs);
      logic exp_b;
      errs = 0;
      for (int k = 0; k < 10 * BPS; k++) begin
         if (k < BPS) exp_b = 1'b0;
         else if (k < 9 * BPS) exp_b = b[3'((k - BPS) / BPS)];
         else exp_b = 1'b1;
         if (uart_txd !== exp_b) errs++;
         if (tx_busy !== 1'b1) errs++;
         tick();
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b1;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      tick();
      tick();
      total_cnt++;
      if (uart_txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", uart_txd);
      else pass_cnt++;
      total_cnt++;
      if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", tx_busy);
      else pass_cnt++;
      total_cnt++;
      if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count);
      else pass_cnt++;
      total_cnt++;
      if (tx_ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", tx_ready);
      else pass_cnt++;
      sys_rst_n = 1'b0;
      #1;
      total_cnt++;
      if (tx_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", tx_ready);
      else pass_cnt++;
   endtask

   task automatic test_single_byte();
      int errs;
      rx_q.delete();
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      tick();
      tx_valid = 1'b0;
      total_cnt++;
      if (fifo_count !== 3'd1 || uart_txd !== 1'b1 || tx_busy !== 1'b0)
         $display("FAIL single_after_push: got count=%0d txd=%b busy=%b expected 1/1/0",
                  fifo_count, uart_txd, tx_busy);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (fifo_count !== 3'd0 || uart_txd !== 1'b0 || tx_busy !== 1'b1)
         $display("FAIL single_after_pop: got count=%0d txd=%b busy=%b expected 0/0/1",
                  fifo_count, uart_txd, tx_busy);
      else pass_cnt++;
      observe_frame(8'h55, errs);
      total_cnt++;
      if (errs !== 0) $display("FAIL single_waveform: got %0d deviations expected 0", errs);
      else pass_cnt++;
      total_cnt++;
      if (tx_busy !== 1'b0 || uart_txd !== 1'b1 || fifo_count !== 3'd0)
         $display("FAIL single_end: got busy=%b txd=%b count=%0d expected 0/1/0",
                  tx_busy, uart_txd, fifo_count);
      else pass_cnt++;
      total_cnt++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h55)
         $display("FAIL single_rx: got %0d bytes first=%h expected 1 byte 55",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int e1, e2;
      rx_q.delete();
      tx_valid = 1'b1;
      tx_data  = 8'hA3;
      tick();
      tx_data  = 8'h0F;
      tick();
      tx_valid = 1'b0;
      total_cnt++;
      if (fifo_count !== 3'd1 || uart_txd !== 1'b0)
         $display("FAIL b2b_start: got count=%0d txd=%b expected 1/0", fifo_count, uart_txd);
      else pass_cnt++;
      observe_frame(8'hA3, e1);
      total_cnt++;
      if (e1 !== 0) $display("FAIL b2b_frame1: got %0d deviations expected 0", e1);
      else pass_cnt++;
      observe_frame(8'h0F, e2);
      total_cnt++;
      if (e2 !== 0) $display("FAIL b2b_frame2: got %0d deviations expected 0", e2);
      else pass_cnt++;
      total_cnt++;
      if (tx_busy !== 1'b0) $display("FAIL b2b_busy_end: got %b expected 0", tx_busy);
      else pass_cnt++;
      total_cnt++;
      if (rx_q.size() != 2 || rx_q[0] !== 8'hA3 || rx_q[1] !== 8'h0F)
         $display("FAIL b2b_rx: got %0d bytes expected A3 0F", rx_q.size());
      else pass_cnt++;
   endtask

   task automatic test_full_fifo();
      bit         all_ready;
      int         pops;
      int         ready_err;
      logic [2:0] prev;
      bit         ok;
      rx_q.delete();
      all_ready = 1'b1;
      tx_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tx_data = 8'(i);
         if (tx_ready !== 1'b1) all_ready = 1'b0;
         tick();
      end
      tx_data = 8'h05;
      total_cnt++;
      if (!all_ready) $display("FAIL full_fill_ready: got a stall expected none during fill");
      else pass_cnt++;
      total_cnt++;
      if (fifo_count !== 3'd4 || tx_ready !== 1'b0)
         $display("FAIL full_state: got count=%0d ready=%b expected 4/0", fifo_count, tx_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (fifo_count !== 3'd4 || tx_ready !== 1'b0)
         $display("FAIL full_hold: got count=%0d ready=%b expected 4/0", fifo_count, tx_ready);
      else pass_cnt++;
      tx_valid  = 1'b0;
      pops      = 0;
      ready_err = 0;
      prev      = fifo_count;
      for (int c = 0; c < 700 && tx_busy === 1'b1; c++) begin
         tick();
         if (fifo_count < prev) begin
            pops++;
            if (tx_ready !== 1'b1) ready_err++;
         end
         prev = fifo_count;
      end
      total_cnt++;
      if (pops !== 4 || ready_err !== 0 || tx_busy !== 1'b0)
         $display("FAIL full_drain: got pops=%0d ready_err=%0d busy=%b expected 4/0/0",
                  pops, ready_err, tx_busy);
      else pass_cnt++;
      ok = (rx_q.size() == 5);
      for (int i = 0; i < rx_q.size() && i < 5; i++) if (rx_q[i] !== 8'(i)) ok = 1'b0;
      total_cnt++;
      if (!ok) $display("FAIL full_rx: got %0d bytes expected 00..04 in order", rx_q.size());
      else pass_cnt++;
   endtask

   task automatic test_pointer_wrap();
      int idx;
      int held;
      bit acc;
      bit ok;
      rx_q.delete();
      idx  = 0;
      held = 0;
      tx_valid = 1'b1;
      tx_data  = 8'h10;
      for (int c = 0; c < 3000 && idx < 20; c++) begin
         acc = (tx_ready === 1'b1);
         if (!acc) held++;
         tick();
         if (acc) idx++;
         tx_data = 8'(8'h10 + idx);
      end
      tx_valid = 1'b0;
      total_cnt++;
      if (idx !== 20) $display("FAIL wrap_accepted: got %0d expected 20", idx);
      else pass_cnt++;
      total_cnt++;
      if (held <= 0) $display("FAIL wrap_backpressure: got %0d stalled cycles expected >0", held);
      else pass_cnt++;
      for (int c = 0; c < 800 && tx_busy === 1'b1; c++) tick();
      total_cnt++;
      if (tx_busy !== 1'b0) $display("FAIL wrap_idle: got busy=%b expected 0", tx_busy);
      else pass_cnt++;
      ok = (rx_q.size() == 20);
      for (int i = 0; i < rx_q.size() && i < 20; i++) if (rx_q[i] !== 8'(8'h10 + i)) ok = 1'b0;
      total_cnt++;
      if (!ok) $display("FAIL wrap_rx: got %0d bytes expected 10..23 in order", rx_q.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      rx_q.delete();
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      tick();
      tx_data  = 8'h01;
      tick();
      tx_valid = 1'b0;
      total_cnt++;
      if (fifo_count !== 3'd1 || uart_txd !== 1'b0)
         $display("FAIL rstmid_start: got count=%0d txd=%b expected 1/0", fifo_count, uart_txd);
      else pass_cnt++;
      repeat (4 * BPS + BPS / 2) tick();
      total_cnt++;
      if (tx_busy !== 1'b1 || uart_txd !== 1'b1)
         $display("FAIL rstmid_bit3: got busy=%b txd=%b expected 1/1", tx_busy, uart_txd);
      else pass_cnt++;
      sys_rst_n = 1'b1;
      tick();
      total_cnt++;
      if (uart_txd !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0)
         $display("FAIL rstmid_after: got txd=%b count=%0d busy=%b expected 1/0/0",
                  uart_txd, fifo_count, tx_busy);
      else pass_cnt++;
      sys_rst_n = 1'b0;
      bad = 0;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad !== 0 || rx_q.size() != 0)
         $display("FAIL rstmid_silent: got %0d active cycles, %0d bytes expected 0/0",
                  bad, rx_q.size());
      else pass_cnt++;
   endtask

   task automatic test_push_pop_same_cycle();
      int e1, e2;
      rx_q.delete();
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      tick();
      tx_data  = 8'hC5;
      tick();
      tx_valid = 1'b0;
      repeat (10 * BPS - 1) tick();
      total_cnt++;
      if (fifo_count !== 3'd1 || uart_txd !== 1'b1)
         $display("FAIL pp_before: got count=%0d txd=%b expected 1/1", fifo_count, uart_txd);
      else pass_cnt++;
      tx_valid = 1'b1;
      tx_data  = 8'h7E;
      tick();
      tx_valid = 1'b0;
      total_cnt++;
      if (fifo_count !== 3'd1 || uart_txd !== 1'b0)
         $display("FAIL pp_count: got count=%0d txd=%b expected 1/0", fifo_count, uart_txd);
      else pass_cnt++;
      observe_frame(8'hC5, e1);
      observe_frame(8'h7E, e2);
      total_cnt++;
      if (e1 !== 0 || e2 !== 0)
         $display("FAIL pp_frames: got %0d/%0d deviations expected 0/0", e1, e2);
      else pass_cnt++;
      total_cnt++;
      if (tx_busy !== 1'b0 || rx_q.size() != 3 || rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC5
          || rx_q[2] !== 8'h7E)
         $display("FAIL pp_rx: got %0d bytes busy=%b expected 3C C5 7E then idle",
                  rx_q.size(), tx_busy);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_full_fifo();
      test_pointer_wrap();
      test_reset_mid_frame();
      test_push_pop_same_cycle();
      total_cnt++;
      if (rx_ferr !== 0) $display("FAIL framing_errors: got %0d expected 0", rx_ferr);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/uart_send_fifo.md
# uart_send_fifo

Byte-oriented UART transmitter with an internal FIFO. It accepts bytes from the test harness or host-side logic over a valid/ready handshake and serialises them as 8N1 frames on `uart_txd`, LSB first. It is the stage directly upstream of the UART receive path: its `uart_txd` drives the receiver's serial input in loopback benches and on the board.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `UART_BPS`, 115200: baud rate. Derived `BPS_CNT = CLK_FREQ/UART_BPS` uses integer division and gives the clocks per bit (434 at the defaults).
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of two and at least 2.
- `sys_clk` input 1: system clock. All logic is on its rising edge.
- `sys_rst_n` input 1: reset. One clock; reset is synchronous and active-high (asserted when 1, despite the suffix).
- `tx_valid` input 1: `tx_data` holds a byte to enqueue.
- `tx_data` input 8: byte to enqueue.
- `tx_ready` output 1: FIFO can accept a byte this cycle.
- `uart_txd` output 1: serial line. Idles high.
- `tx_busy` output 1: a frame is being transmitted (FSM not in IDLE).
- `fifo_count` output clog2(FIFO_DEPTH)+1: number of bytes currently queued.

## Operation
- **FIFO**
  - Circular buffer with wrapping read and write pointers plus an occupancy counter.
  - Push occurs when `tx_valid && tx_ready`.
  - `tx_ready = (fifo_count != FIFO_DEPTH) && !sys_rst_n`.
  - A push while full is impossible because `tx_ready` is 0. The byte is not accepted, and the source must hold it.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - Pointers wrap from FIFO_DEPTH-1 to 0.
- **FSM states:** IDLE, START, DATA, STOP. Internal state:
  - `clk_cnt`: 16-bit, counts 0..BPS_CNT-1.
  - `bit_idx`: 3-bit.
  - `shift`: 8-bit.
- **IDLE**
  - `uart_txd` = 1.
  - If `fifo_count != 0`: pop the head into `shift`, set `clk_cnt` = 0, go to START.
- **START**
  - `uart_txd` = 0 for BPS_CNT cycles.
  - At `clk_cnt == BPS_CNT-1`: go to DATA with `bit_idx` = 0.
- **DATA**
  - `uart_txd = shift[bit_idx]`, each bit held for BPS_CNT cycles.
  - At `clk_cnt == BPS_CNT-1`: if `bit_idx == 7`, go to STOP; otherwise increment `bit_idx`.
- **STOP**
  - `uart_txd` = 1 for BPS_CNT cycles.
  - At `clk_cnt == BPS_CNT-1`:
    - If the FIFO is non-empty: pop, load `shift`, go directly to START. This gives back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- `clk_cnt` resets to 0 on every state transition and is held at 0 in IDLE.
- `uart_txd` is driven from a register, so the line never glitches.
- Bytes pushed while a frame is in flight only queue; they never disturb the current frame.

## Timing
- **Reset values:**
  - `uart_txd` = 1, `tx_busy` = 0, `fifo_count` = 0.
  - `tx_ready` = 0 while reset is asserted, and 1 in the first cycle after reset deasserts.
  - The FSM is in IDLE; pointers are 0.
- **Reset mid-frame:** on the next edge `uart_txd` returns to 1 and the queued bytes are discarded.
- **Latency:**
  - Push accepted on edge N.
  - `fifo_count` = 1 after edge N.
  - FSM pops on edge N+1; `uart_txd` falls and `tx_busy` rises after edge N+1.
- **Frame length:** exactly 10×BPS_CNT cycles from the start-bit edge to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **`tx_busy`:**
  - Falls after the final stop-bit cycle, only if the FIFO is empty.
  - Remains 1 continuously across back-to-back frames.
- **`fifo_count` during a pop:** decrements on the edge that enters START from IDLE or STOP.

## Test plan
Bench parameters for all scenarios: CLK_FREQ=1000, UART_BPS=100, so BPS_CNT=10.

1. **Single byte.** Push 0x55 one cycle after reset.
   - `uart_txd` low for 10 cycles, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10 cycles.
   - Total 100 cycles.
   - `tx_busy` then drops and `fifo_count` = 0.
2. **Back-to-back.** Push 0xA3 and 0x0F on consecutive cycles.
   - Frames are contiguous: the second start bit begins at cycle offset 100 from the first.
   - `tx_busy` stays 1 for 200 cycles.
   - A bench receiver model decodes 0xA3 then 0x0F.
3. **Full FIFO.**
   - With FIFO_DEPTH=4, hold `tx_valid` high with 0x00 followed by incrementing data.
   - The first byte is popped, so `fifo_count` reaches 4 and `tx_ready` = 0.
   - Bytes offered while `tx_ready` is low are not lost: the source holds them.
   - Exactly 0x00..0x04 are transmitted in order.
   - `tx_ready` returns to 1 the cycle after each pop.
4. **Pointer wrap.**
   - Stream 20 bytes 0x10..0x23 through FIFO_DEPTH=4.
   - Every byte is received in order with no duplicates or drops.
5. **Reset mid-frame.**
   - Push 0xFF and 0x01; assert `sys_rst_n` for 1 cycle during bit 3 of the first frame.
   - Next cycle: `uart_txd` = 1, `fifo_count` = 0, `tx_busy` = 0.
   - No further frames are sent.
6. **Simultaneous push and pop.**
   - Push 0x7E on the exact cycle the STOP→START pop occurs, with one byte queued.
   - `fifo_count` is unchanged (1→1).
   - 0x7E is sent as the following frame.
